// File: rtl/rv32ima_pkg.sv
// rtl/rv32ima_pkg.sv - shared load/store encodings and memory responder state type
package rv32ima_pkg;

    localparam logic [1:0] LDST_BYTE = 2'd0;
    localparam logic [1:0] LDST_HALF = 2'd1;
    localparam logic [1:0] LDST_WORD = 2'd2;

    localparam logic [31:0] MISALIGN_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mem_state_t;

endpackage

// File: rtl/datapath_if.sv
// rtl/datapath_if.sv - core datapath to memory request/response bundle
interface datapath_if;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic [31:0] imem_load;
    logic        ihit;
    logic        dmem_ren;
    logic        dmem_wen;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_store;
    logic [1:0]  dmem_width;
    logic [31:0] dmem_load;
    logic        dhit;

    modport mem (
        input  imem_ren, imem_addr, dmem_ren, dmem_wen, dmem_addr, dmem_store, dmem_width,
        output imem_load, ihit, dmem_load, dhit
    );

    modport dp (
        output imem_ren, imem_addr, dmem_ren, dmem_wen, dmem_addr, dmem_store, dmem_width,
        input  imem_load, ihit, dmem_load, dhit
    );
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane enables, store replication and load extraction for sub-word accesses
module mem_lane_align
    import rv32ima_pkg::*;
(
    input  logic [1:0]  width,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] byte_shifted;
    logic [31:0] half_shifted;

    always_comb begin
        byte_shifted = rdata >> {addr_lo, 3'b000};
        half_shifted = rdata >> {addr_lo[1], 4'b0000};
        byte_en      = 4'b1111;
        wdata        = store_data;
        load_data    = rdata;
        case (width)
            LDST_BYTE: begin
                byte_en   = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = {24'h0, byte_shifted[7:0]};
            end
            LDST_HALF: begin
                // addr[0] is deliberately ignored: misaligned halves snap to the lower lane pair
                byte_en   = 4'b0011 << {addr_lo[1], 1'b0};
                wdata     = {2{store_data[15:0]}};
                load_data = {16'h0, half_shifted[15:0]};
            end
            default: begin
                byte_en   = 4'b1111;
                wdata     = store_data;
                load_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - I/D request arbiter and single-port RAM sequencer with registered load return
// Optional build macro MEM_MISALIGN_CHECK_EN: trap misaligned data accesses and add the misaligned port.
module mem_responder
    import rv32ima_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter bit D_PRIORITY = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    datapath_if.mem           dpif,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [3:0]        ram_byte_en,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic              misaligned,
`endif
    input  logic              ram_ready
);

    mem_state_t  state_q, state_d;
    logic        src_d_q, src_d_d;
    logic        wr_q, wr_d;
    logic [1:0]  width_q, width_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] store_q, store_d;
    logic        i_turn_q, i_turn_d;
    logic [31:0] imem_load_q, imem_load_d;
    logic [31:0] dmem_load_q, dmem_load_d;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        mis_q, mis_d;
    logic        mis_req;
`endif

    logic        d_req, i_req, grant_d, in_access, in_resp;
    logic [3:0]  be;
    logic [31:0] wd, ld;

    mem_lane_align u_align (
        .width      (width_q),
        .addr_lo    (addr_q[1:0]),
        .store_data (store_q),
        .rdata      (ram_rdata),
        .byte_en    (be),
        .wdata      (wd),
        .load_data  (ld)
    );

    assign d_req = dpif.dmem_ren | dpif.dmem_wen;
    assign i_req = dpif.imem_ren;
    // i_turn_q gives I one guaranteed grant after D won a contested cycle
    assign grant_d = d_req && (!i_req || (D_PRIORITY && !i_turn_q));

    always_comb begin
        state_d     = state_q;
        src_d_d     = src_d_q;
        wr_d        = wr_q;
        width_d     = width_q;
        addr_d      = addr_q;
        store_d     = store_q;
        i_turn_d    = i_turn_q;
        imem_load_d = imem_load_q;
        dmem_load_d = dmem_load_q;
`ifdef MEM_MISALIGN_CHECK_EN
        mis_d   = mis_q;
        mis_req = 1'b0;
        case (dpif.dmem_width)
            LDST_BYTE: mis_req = 1'b0;
            LDST_HALF: mis_req = dpif.dmem_addr[0];
            default:   mis_req = (dpif.dmem_addr[1:0] != 2'b00);
        endcase
`endif
        case (state_q)
            IDLE: begin
                if (d_req || i_req) begin
                    src_d_d  = grant_d;
                    wr_d     = grant_d && dpif.dmem_wen;
                    width_d  = grant_d ? dpif.dmem_width : LDST_WORD;
                    addr_d   = grant_d ? dpif.dmem_addr : dpif.imem_addr;
                    store_d  = dpif.dmem_store;
                    i_turn_d = grant_d && i_req && D_PRIORITY;
                    state_d  = ACCESS;
`ifdef MEM_MISALIGN_CHECK_EN
                    mis_d = grant_d && mis_req;
                    if (grant_d && mis_req) begin
                        state_d     = RESP;
                        dmem_load_d = MISALIGN_DATA;
                    end
`endif
                end
            end
            ACCESS: begin
                if (ram_ready) begin
                    if (!src_d_q) begin
                        imem_load_d = ld;
                    end else if (!wr_q) begin
                        dmem_load_d = ld;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            src_d_q     <= 1'b0;
            wr_q        <= 1'b0;
            width_q     <= LDST_WORD;
            addr_q      <= 32'h0;
            store_q     <= 32'h0;
            i_turn_q    <= 1'b0;
            imem_load_q <= 32'h0;
            dmem_load_q <= 32'h0;
`ifdef MEM_MISALIGN_CHECK_EN
            mis_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            src_d_q     <= src_d_d;
            wr_q        <= wr_d;
            width_q     <= width_d;
            addr_q      <= addr_d;
            store_q     <= store_d;
            i_turn_q    <= i_turn_d;
            imem_load_q <= imem_load_d;
            dmem_load_q <= dmem_load_d;
`ifdef MEM_MISALIGN_CHECK_EN
            mis_q       <= mis_d;
`endif
        end
    end

    assign in_access   = (state_q == ACCESS);
    assign in_resp     = (state_q == RESP);
    assign ram_ren     = in_access && !wr_q;
    assign ram_wen     = in_access && wr_q;
    assign ram_addr    = in_access ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign ram_byte_en = ram_wen ? be : 4'b0000;
    assign ram_wdata   = ram_wen ? wd : 32'h0;

    // A hit is withheld if the core dropped its request while we were finishing
    assign dpif.dhit      = in_resp && src_d_q && d_req;
    assign dpif.ihit      = in_resp && !src_d_q && i_req;
    assign dpif.imem_load = imem_load_q;
    assign dpif.dmem_load = dmem_load_q;
`ifdef MEM_MISALIGN_CHECK_EN
    assign misaligned     = dpif.dhit && mis_q;
`endif

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side end of the datapath/memory interface: implements the `mem` modport of `datapath_if`.
- Serves instruction fetches and data loads/stores from the core over one shared single-ported RAM port.
- Arbitrates between I and D requests, generates byte enables and lane alignment for sub-word accesses, and returns registered load data with single-cycle `ihit`/`dhit` pulses.
- Sits between the core datapath and the RAM model / future cache layer.

Parameters:
- ADDR_W, 32, RAM-side address width; upper bits of the 32-bit request address are dropped.
- D_PRIORITY, 1, 1 = data request wins a simultaneous I/D request; 0 = instruction wins.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- dpif  modport  datapath_if.mem  core-side request/response bundle (imem_*, dmem_*, ihit, dhit).
- ram_addr  output  ADDR_W  word-aligned RAM address; low 2 bits are always 0.
- ram_ren  output  1  RAM read strobe.
- ram_wen  output  1  RAM write strobe.
- ram_byte_en  output  4  byte-lane enables for writes.
- ram_wdata  output  32  lane-shifted store data.
- ram_rdata  input  32  RAM read data; valid when ram_ready=1.
- ram_ready  input  1  RAM completion; may be high in the first access cycle.

Behaviour:
- Reset (clock and reset fixed): one clock CLK; reset RST is synchronous and active-high. On reset: state=IDLE; ihit=0, dhit=0, imem_load=0, dmem_load=0; all ram_* outputs 0. Reset mid-access aborts the access with no hit, and ram_ren/ram_wen drop in the next cycle.
- States: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If dmem_ren|dmem_wen or imem_ren is high, select a source (D_PRIORITY breaks ties), latch address/width/store data/op, and go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - Drive ram_* from the latched request, held stable until ram_ready.
  - On ram_ready, capture the aligned result and go to RESP.
- RESP:
  - Pulse ihit or dhit for exactly 1 cycle according to the served source.
  - The hit is suppressed if the source's request signal has dropped in RESP (abandoned request).
  - Return to IDLE.
- Minimum latency: request seen in cycle 0, hit in cycle 2; extra RAM wait cycles add 1:1.
- dmem_ren and dmem_wen both high is illegal; it is handled as a write.
- Width encoding (package constants): LDST_BYTE=0, LDST_HALF=1, LDST_WORD=2; value 3 is treated as WORD.
- Stores:
  - byte_en = 0001<<addr[1:0] (BYTE), 0011<<{addr[1],0} (HALF), 1111 (WORD).
  - wdata = store value replicated into the selected lanes.
- Loads:
  - Result = selected lanes shifted to bit 0, zero-extended. Sign extension is the datapath's job.
  - imem fetches are always WORD.
- Misaligned HALF/WORD accesses: address low bits are masked (HALF uses addr[1], WORD ignores addr[1:0]), with no error.
- dmem_load/imem_load hold their value until the next completion of the same source.
- Writes return dhit; dmem_load is left unchanged.
- Starvation: after serving D, if D_PRIORITY=1 and both I and D are pending, the next grant goes to I (one-shot fairness toggle).

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- With the macro defined:
  - A misaligned HALF (addr[0]=1) or WORD (addr[1:0]!=0) data access never enters ACCESS.
  - Goes IDLE -> RESP; dhit pulses; dmem_load=32'hDEAD_BEEF; no RAM strobe.
  - Output port `misaligned` (1 bit) pulses with dhit.
- Without the macro: masking behaviour as above; no `misaligned` port.

Decomposition:
- rv32ima_pkg gains:
  - LDST_BYTE/HALF/WORD constants;
  - mem_state_t enum (IDLE, ACCESS, RESP);
  - MISALIGN_DATA constant.
- One sub-module: mem_lane_align (combinational). Inputs: width, addr[1:0], store data, raw read data. Outputs: byte_en, shifted wdata, extracted load data. It is reused later by the dcache.

Test Plan:
- imem_ren=1, addr=0x100, RAM word 0x00C0FFEE, ram_ready immediate -> ihit pulse in cycle 2, imem_load=0x00C0FFEE, ram_addr=0x100.
- Byte store 0xAB to 0x203 -> ram_byte_en=1000, ram_wdata=0xABABABAB, ram_addr=0x200, dhit one cycle. Then byte load 0x203 -> dmem_load=0x000000AB.
- Simultaneous imem_ren@0x0 and dmem_ren@0x40, D_PRIORITY=1 -> dhit first; I served next despite a new D request; ihit follows.
- ram_ready delayed 3 cycles -> ram_ren/ram_addr stable throughout; hit in cycle 5.
- RST asserted during ACCESS -> next cycle all outputs 0, state IDLE, no hit; a new request afterwards is served normally.
- With MEM_MISALIGN_CHECK_EN: word load at 0x102 -> no ram_ren; dhit and misaligned pulse; dmem_load=0xDEADBEEF. Without the macro: reads 0x100.
